// File: rtl/systolic_matmul_os.sv
// Output-stationary RxC systolic matrix-multiply engine with internal operand skew,
// valid/ready streaming, array-wide stall and row-serial result drain.
module systolic_matmul_os #(
  parameter int BW     = 8,
  parameter int R      = 4,
  parameter int C      = 4,
  parameter int K_MAX  = 16,
  parameter int SIGNED = 1,
  parameter int KW     = $clog2(K_MAX + 1),
  parameter int ACC_W  = 2*BW + $clog2(K_MAX),
  localparam int IW    = (R > 1) ? $clog2(R) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KW-1:0]      cfg_k,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [R*BW-1:0]    in_a,
  input  logic [C*BW-1:0]    in_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [C*ACC_W-1:0] res_row,
  output logic [IW-1:0]      res_idx,
  output logic               done
);
  localparam int FW = $clog2(R + C);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} stateT;
  stateT state, stateNext;

  logic [KW-1:0]    kTarget, beatCnt;
  logic [FW-1:0]    flushCnt;
  logic [IW-1:0]    rowIdx;
  logic             advance, clearArr;
  logic [R*BW-1:0]  opA;
  logic [C*BW-1:0]  opB;

  logic [BW-1:0]    skA [R][R];
  logic [BW-1:0]    skB [C][C];
  logic [BW-1:0]    aEdge [R];
  logic [BW-1:0]    bEdge [C];
  logic [BW-1:0]    aFwd [R][C];
  logic [BW-1:0]    bFwd [R][C];
  logic [BW-1:0]    aIn [R][C];
  logic [BW-1:0]    bIn [R][C];
  logic [ACC_W-1:0] acc [R][C];
  logic [ACC_W-1:0] prodExt [R][C];

  function automatic logic [ACC_W-1:0] mulExt(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic signed [2*BW-1:0] aS, bS, pS;
    logic [2*BW-1:0]        aU, bU, pU;
    aS = (2*BW)'($signed(a));
    bS = (2*BW)'($signed(b));
    pS = aS * bS;
    aU = (2*BW)'(a);
    bU = (2*BW)'(b);
    pU = aU * bU;
    return (SIGNED != 0) ? ACC_W'(pS) : ACC_W'(pU);
  endfunction

  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign res_valid = (state == DRAIN);
  assign res_idx   = rowIdx;

  assign clearArr = (state == IDLE) && start;
  assign advance  = ((state == LOAD) && in_valid) || (state == FLUSH);
  assign opA      = (state == LOAD) ? in_a : '0;
  assign opB      = (state == LOAD) ? in_b : '0;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (start) stateNext = (cfg_k == '0) ? FLUSH : LOAD;
      LOAD:    if (in_valid && (beatCnt == kTarget - KW'(1))) stateNext = FLUSH;
      FLUSH:   if (flushCnt == FW'(R + C - 2)) stateNext = DRAIN;
      DRAIN:   if (res_ready && (rowIdx == IW'(R - 1))) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      kTarget  <= '0;
      beatCnt  <= '0;
      flushCnt <= '0;
      rowIdx   <= '0;
      done     <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= (state == DRAIN) && res_ready && (rowIdx == IW'(R - 1));
      case (state)
        IDLE: if (start) begin
          kTarget  <= (cfg_k > KW'(K_MAX)) ? KW'(K_MAX) : cfg_k;
          beatCnt  <= '0;
          flushCnt <= '0;
          rowIdx   <= '0;
        end
        LOAD:    if (in_valid) beatCnt <= beatCnt + KW'(1);
        FLUSH:   flushCnt <= flushCnt + FW'(1);
        DRAIN:   if (res_ready) rowIdx <= (rowIdx == IW'(R - 1)) ? '0 : rowIdx + IW'(1);
        default: ;
      endcase
    end
  end

  // Skew lines are full-length shift registers per lane; lane i taps stage i-1 (lane 0 bypasses).
  always_ff @(posedge clk) begin
    if (rst || clearArr) begin
      for (int unsigned i = 0; i < R; i++)
        for (int unsigned s = 0; s < R; s++) skA[i][s] <= '0;
      for (int unsigned j = 0; j < C; j++)
        for (int unsigned s = 0; s < C; s++) skB[j][s] <= '0;
    end else if (advance) begin
      for (int unsigned i = 0; i < R; i++) begin
        skA[i][0] <= opA[i*BW +: BW];
        for (int unsigned s = 1; s < R; s++) skA[i][s] <= skA[i][s-1];
      end
      for (int unsigned j = 0; j < C; j++) begin
        skB[j][0] <= opB[j*BW +: BW];
        for (int unsigned s = 1; s < C; s++) skB[j][s] <= skB[j][s-1];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < R; i++) aEdge[i] = opA[i*BW +: BW];
    for (int unsigned i = 1; i < R; i++) aEdge[i] = skA[i][i-1];
    for (int unsigned j = 0; j < C; j++) bEdge[j] = opB[j*BW +: BW];
    for (int unsigned j = 1; j < C; j++) bEdge[j] = skB[j][j-1];

    for (int unsigned i = 0; i < R; i++) begin
      aIn[i][0] = aEdge[i];
      for (int unsigned j = 1; j < C; j++) aIn[i][j] = aFwd[i][j-1];
    end
    for (int unsigned j = 0; j < C; j++) begin
      bIn[0][j] = bEdge[j];
      for (int unsigned i = 1; i < R; i++) bIn[i][j] = bFwd[i-1][j];
    end

    for (int unsigned i = 0; i < R; i++)
      for (int unsigned j = 0; j < C; j++)
        prodExt[i][j] = mulExt(aIn[i][j], bIn[i][j]);
  end

  // Each PE multiplies the operands arriving this step and forwards them one hop.
  always_ff @(posedge clk) begin
    if (rst || clearArr) begin
      for (int unsigned i = 0; i < R; i++)
        for (int unsigned j = 0; j < C; j++) begin
          aFwd[i][j] <= '0;
          bFwd[i][j] <= '0;
          acc[i][j]  <= '0;
        end
    end else if (advance) begin
      for (int unsigned i = 0; i < R; i++)
        for (int unsigned j = 0; j < C; j++) begin
          aFwd[i][j] <= aIn[i][j];
          bFwd[i][j] <= bIn[i][j];
          acc[i][j]  <= acc[i][j] + prodExt[i][j];
        end
    end
  end

  always_comb begin
    res_row = '0;
    for (int unsigned j = 0; j < C; j++) res_row[j*ACC_W +: ACC_W] = acc[rowIdx][j];
  end

endmodule

// File: tb/tb_systolic_matmul_os.sv
// Directed bench for systolic_matmul_os: matrix-product model, per-cycle result/done checker.
module tb_systolic_matmul_os;
  localparam int BW    = 8;
  localparam int R     = 4;
  localparam int C     = 4;
  localparam int K_MAX = 16;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int ACC_W = 2*BW + $clog2(K_MAX);
  localparam int IW    = $clog2(R);

  logic               clk = 1'b0;
  logic               rst, start, in_valid, res_ready;
  logic [KW-1:0]      cfg_k;
  logic [R*BW-1:0]    in_a;
  logic [C*BW-1:0]    in_b;
  logic               busy, in_ready, res_valid, done;
  logic [C*ACC_W-1:0] res_row;
  logic [IW-1:0]      res_idx;

  always #5 clk = ~clk;

  systolic_matmul_os #(.BW(BW), .R(R), .C(C), .K_MAX(K_MAX), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_row(res_row),
    .res_idx(res_idx), .done(done)
  );

  int total = 0;
  int bad   = 0;
  int mA [R][K_MAX];
  int mB [K_MAX][C];
  logic [ACC_W-1:0]   expC [R][C];
  logic [C*ACC_W-1:0] seenRow [R];
  int expRow   = 0;
  bit pendDone = 1'b0;
  int doneCnt  = 0;

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic checkVec(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic int sval(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic void buildExp(input int k);
    int kEff, s;
    kEff = (k > K_MAX) ? K_MAX : k;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int kk = 0; kk < kEff; kk++) s += sval(mA[i][kk]) * sval(mB[kk][j]);
        expC[i][j] = s[ACC_W-1:0];
      end
  endfunction

  function automatic logic [C*ACC_W-1:0] packRow(input int i);
    logic [C*ACC_W-1:0] r;
    for (int j = 0; j < C; j++) r[j*ACC_W +: ACC_W] = expC[i][j];
    return r;
  endfunction

  // Result checker: the row shown must match the model and advance only on acceptance.
  always @(negedge clk) begin
    if (rst) begin
      expRow   = 0;
      pendDone = 1'b0;
    end else begin
      check("donePulse", done, pendDone);
      if (done) doneCnt++;
      pendDone = 1'b0;
      if (res_valid) begin
        check("resIdx", res_idx, expRow);
        checkVec("resRow", res_row, packRow(expRow));
        seenRow[res_idx] = res_row;
        if (res_ready) begin
          pendDone = (expRow == R - 1);
          expRow   = (expRow + 1) % R;
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the done cycle.
  task automatic runJob(input int k, input bit sparseValid, input int stallRow, input int stallLen,
                        input int expLat, input bit abortInFlush);
    int beat = 0, cyc = 0, stallCnt = 0, lat = -1, loadCyc = 0;
    bit seenDone = 1'b0;
    buildExp(k);
    start = 1'b1;
    cfg_k = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_k = KW'($urandom);
    cyc = 1;
    while (cyc < 400) begin
      check("busyHeld", busy, 1);
      if (res_valid && lat < 0) lat = cyc;
      if (abortInFlush && beat >= k && !in_ready && !res_valid) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check("abortBusy", busy, 0);
        check("abortResValid", res_valid, 0);
        check("abortInReady", in_ready, 0);
        check("abortDone", done, 0);
        rst = 1'b0;
        return;
      end
      in_a = R*BW'($urandom);
      in_b = C*BW'($urandom);
      if (in_ready) begin
        in_valid = sparseValid ? ((loadCyc % 3) == 0) : 1'b1;
        loadCyc++;
        if (in_valid) begin
          for (int i = 0; i < R; i++) in_a[i*BW +: BW] = BW'(mA[i][beat]);
          for (int j = 0; j < C; j++) in_b[j*BW +: BW] = BW'(mB[beat][j]);
          beat++;
        end
      end else begin
        in_valid = 1'b1;
      end
      if (res_valid && res_idx == stallRow && stallCnt < stallLen) begin
        res_ready = 1'b0;
        stallCnt++;
      end else begin
        res_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        seenDone = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    check("jobDone", seenDone, 1);
    if (expLat >= 0) check("latency", lat, expLat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_k = '0; in_valid = 1'b0; res_ready = 1'b1;
    in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rstBusy", busy, 0);
    check("rstInReady", in_ready, 0);
    check("rstResValid", res_valid, 0);
    check("rstDone", done, 0);
    checkVec("rstRow", res_row, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: identity A, B[k][j] = 4k+j
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K_MAX; k++) mA[i][k] = (i == k) ? 1 : 0;
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < C; j++) mB[k][j] = (k * 4 + j) & 255;
    buildExp(4);
    checkVec("modelIdentRow1", packRow(1), {20'd7, 20'd6, 20'd5, 20'd4});
    runJob(4, 1'b0, -1, 0, 12, 1'b0);
    checkVec("identRow1", seenRow[1], {20'd7, 20'd6, 20'd5, 20'd4});

    // 3: sparse in_valid, same result; 4: stall on row 2
    runJob(4, 1'b1, -1, 0, -1, 1'b0);
    checkVec("sparseRow1", seenRow[1], {20'd7, 20'd6, 20'd5, 20'd4});
    runJob(4, 1'b0, 2, 5, 12, 1'b0);
    checkVec("stallRow2", seenRow[2], {20'd11, 20'd10, 20'd9, 20'd8});

    // 2: all -128, full length
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K_MAX; k++) mA[i][k] = 128;
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < C; j++) mB[k][j] = 128;
    buildExp(16);
    check("modelNeg128", expC[0][0], 20'h40000);
    runJob(16, 1'b0, -1, 0, 24, 1'b0);
    checkVec("neg128Row3", seenRow[3], {4{20'h40000}});

    // 5: zero-length job straight after a large result, then back-to-back jobs
    runJob(0, 1'b0, -1, 0, 8, 1'b0);
    checkVec("zeroRow0", seenRow[0], '0);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K_MAX; k++) mA[i][k] = (i * 7 + k * 3 + 1) & 255;
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < C; j++) mB[k][j] = (k * 37 + j * 11 + 200) & 255;
    runJob(2, 1'b0, -1, 0, 10, 1'b0);
    // cfg_k above K_MAX clamps to K_MAX beats
    runJob(31, 1'b1, 1, 2, -1, 1'b0);

    // 6: reset during FLUSH, then all-ones job
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K_MAX; k++) mA[i][k] = (i == k) ? 1 : 0;
    runJob(4, 1'b0, -1, 0, -1, 1'b1);
    for (int i = 0; i < R; i++)
      for (int k = 0; k < K_MAX; k++) mA[i][k] = 255;
    for (int k = 0; k < K_MAX; k++)
      for (int j = 0; j < C; j++) mB[k][j] = 255;
    buildExp(3);
    check("modelOnes", expC[2][1], 3);
    runJob(3, 1'b0, -1, 0, 11, 1'b0);
    checkVec("onesRow0", seenRow[0], {4{20'd3}});

    repeat (3) @(posedge clk);
    #1;
    check("idleAfter", busy, 0);
    check("doneCount", doneCnt, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
